// File: rtl/axi_ar_req_queue.sv
// rtl/axi_ar_req_queue.sv - AXI4 AR request queue with FWFT output, level flags, flush and WRAP length error flag
module axi_ar_req_queue #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [ADDR_WIDTH-1:0]    s_araddr,
    input  logic [ID_WIDTH-1:0]      s_arid,
    input  logic [1:0]               s_arburst,
    input  logic [2:0]               s_arsize,
    input  logic [7:0]               s_arlen,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [ADDR_WIDTH-1:0]    m_araddr,
    output logic [ID_WIDTH-1:0]      m_arid,
    output logic [1:0]               m_arburst,
    output logic [2:0]               m_arsize,
    output logic [7:0]               m_arlen,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     full,
    output logic                     empty,
    output logic                     err_wrap_len
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = ADDR_WIDTH + ID_WIDTH + 2 + 3 + 8;
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] LVL_AF   = (PW+1)'(AF_THRESH);
    localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);

    logic [EW-1:0] mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          push;
    logic          pop;
    logic          wrap_len_bad;

    // Pointers carry a wrap bit, so their difference is the occupancy 0..DEPTH.
    assign level       = wr_ptr - rd_ptr;
    assign full        = (level == LVL_FULL);
    assign empty       = (level == '0);
    assign almost_full = (level >= LVL_AF);

    assign s_arready = !full;
    assign m_arvalid = !empty;
    assign push      = s_arvalid & s_arready;
    assign pop       = m_arvalid & m_arready;

    assign wrap_len_bad = (s_arburst == 2'b10) &&
                          !(s_arlen inside {8'd1, 8'd3, 8'd7, 8'd15});

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            err_wrap_len <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && wrap_len_bad) begin
                err_wrap_len <= 1'b1;
            end
        end
    end

    // Storage has no reset; stale entries are masked by m_arvalid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr[PW-1:0]] <= {s_araddr, s_arid, s_arburst, s_arsize, s_arlen};
        end
    end

    assign {m_araddr, m_arid, m_arburst, m_arsize, m_arlen} = mem[rd_ptr[PW-1:0]];

endmodule
